// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter merging an ALU and a load source onto one register-file write port,
// with a one-cycle registered write stage and read bypass of the in-flight write.
module regfile_wb_arbiter #(
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   input  logic [4:0]  a_ws,
   input  logic [31:0] a_wd,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [4:0]  b_ws,
   input  logic [31:0] b_wd,
   output logic        b_ready,
   output logic        rf_we,
   output logic [4:0]  rf_ws,
   output logic [31:0] rf_wd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] rf_rd1,
   input  logic [31:0] rf_rd2,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } grant_e;

   grant_e          last_grant_q, last_grant_d;
   logic            rf_we_q, rf_we_d;
   logic [AW-1:0]   rf_ws_q, rf_ws_d;
   logic [DW-1:0]   rf_wd_q, rf_wd_d;
   logic            grant_a, grant_b;

   // Grant: a lone requester wins outright; a tie goes to A under fixed priority,
   // otherwise to whichever source was not granted last.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!rst) begin
         if (a_valid && b_valid) begin
            if ((FIXED_PRIO != 0) || (last_grant_q == GRANT_B)) begin
               grant_a = 1'b1;
            end else begin
               grant_b = 1'b1;
            end
         end else begin
            grant_a = a_valid;
            grant_b = b_valid;
         end
      end
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   // Next state: writes to x0 are accepted and consume the grant but never reach the port.
   always_comb begin
      last_grant_d = last_grant_q;
      rf_we_d      = 1'b0;
      rf_ws_d      = rf_ws_q;
      rf_wd_d      = rf_wd_q;
      if (grant_a) begin
         last_grant_d = GRANT_A;
         if (a_ws != '0) begin
            rf_we_d = 1'b1;
            rf_ws_d = a_ws;
            rf_wd_d = a_wd;
         end
      end else if (grant_b) begin
         last_grant_d = GRANT_B;
         if (b_ws != '0) begin
            rf_we_d = 1'b1;
            rf_ws_d = b_ws;
            rf_wd_d = b_wd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= GRANT_B;
         rf_we_q      <= 1'b0;
         rf_ws_q      <= '0;
         rf_wd_q      <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         rf_we_q      <= rf_we_d;
         rf_ws_q      <= rf_ws_d;
         rf_wd_q      <= rf_wd_d;
      end
   end

   assign rf_we = rf_we_q;
   assign rf_ws = rf_ws_q;
   assign rf_wd = rf_wd_q;

   // Read bypass: the write being committed this cycle is newer than the raw read data.
   always_comb begin
      rd1 = rf_rd1;
      if (rs1 == '0) begin
         rd1 = '0;
      end else if (rf_we_q && (rf_ws_q == rs1)) begin
         rd1 = rf_wd_q;
      end
   end

   always_comb begin
      rd2 = rf_rd2;
      if (rs2 == '0) begin
         rd2 = '0;
      end else if (rf_we_q && (rf_ws_q == rs2)) begin
         rd2 = rf_wd_q;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: instance 0 is round-robin, instance 1 is fixed-priority;
// directed scenarios followed by randomized traffic against a transaction-level model.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid [2];
   logic [4:0]  a_ws    [2];
   logic [31:0] a_wd    [2];
   logic        a_ready [2];
   logic        b_valid [2];
   logic [4:0]  b_ws    [2];
   logic [31:0] b_wd    [2];
   logic        b_ready [2];
   logic        rf_we   [2];
   logic [4:0]  rf_ws   [2];
   logic [31:0] rf_wd   [2];
   logic [4:0]  rs1, rs2;
   logic [31:0] rf_rd1, rf_rd2;
   logic [31:0] rd1     [2];
   logic [31:0] rd2     [2];

   int checks = 0;
   int errors = 0;

   // Reference model state: who won most recently, and the write queued for the port.
   int          m_last  [2];
   bit          m_we    [2];
   logic [4:0]  m_ws    [2];
   logic [31:0] m_wd    [2];
   bit          m_known [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      regfile_wb_arbiter #(.FIXED_PRIO(g)) u_dut (
         .clk     (clk),
         .rst     (rst),
         .a_valid (a_valid[g]),
         .a_ws    (a_ws[g]),
         .a_wd    (a_wd[g]),
         .a_ready (a_ready[g]),
         .b_valid (b_valid[g]),
         .b_ws    (b_ws[g]),
         .b_wd    (b_wd[g]),
         .b_ready (b_ready[g]),
         .rf_we   (rf_we[g]),
         .rf_ws   (rf_ws[g]),
         .rf_wd   (rf_wd[g]),
         .rs1     (rs1),
         .rs2     (rs2),
         .rf_rd1  (rf_rd1),
         .rf_rd2  (rf_rd2),
         .rd1     (rd1[g]),
         .rd2     (rd2[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 2; i++) begin
         a_valid[i] = 1'b0; a_ws[i] = 5'd0; a_wd[i] = 32'd0;
         b_valid[i] = 1'b0; b_ws[i] = 5'd0; b_wd[i] = 32'd0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_last[i] = 1; m_we[i] = 1'b0; m_ws[i] = 5'd0; m_wd[i] = 32'd0; m_known[i] = 1'b1;
      end
   endtask

   // Who should be accepted this cycle, from the arbitration rules.
   function automatic void arb(input bit r, input bit av, input bit bv, input int fixed,
                               input int last, output bit ga, output bit gb);
      ga = 1'b0;
      gb = 1'b0;
      if (!r) begin
         if (av && bv) begin
            if (fixed != 0 || last == 1) ga = 1'b1;
            else gb = 1'b1;
         end else begin
            ga = av;
            gb = bv;
         end
      end
   endfunction

   // Newest architectural value of a register as seen by a reader this cycle.
   function automatic logic [31:0] exp_rd(input int i, input logic [4:0] rs, input logic [31:0] raw);
      if (rs == 5'd0) return 32'd0;
      if (m_we[i] && m_ws[i] == rs) return m_wd[i];
      return raw;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a_valid[i] = 1'b1; a_ws[i] = 5'd1; a_wd[i] = 32'h1;
         b_valid[i] = 1'b1; b_ws[i] = 5'd2; b_wd[i] = 32'h2;
      end
      rs1 = 5'd3; rs2 = 5'd0; rf_rd1 = 32'h1111; rf_rd2 = 32'h2222;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (a_ready[i] !== 1'b0 || b_ready[i] !== 1'b0) begin
            errors++; $display("FAIL reset_ready[%0d]: got a=%b b=%b expected 0 0", i, a_ready[i], b_ready[i]);
         end
      end
      tick();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (rf_we[i] !== 1'b0 || rf_ws[i] !== 5'd0 || rf_wd[i] !== 32'd0) begin
            errors++; $display("FAIL reset_out[%0d]: got we=%b ws=%0d wd=%h expected 0 0 0", i, rf_we[i], rf_ws[i], rf_wd[i]);
         end
         checks++;
         if (rd1[i] !== 32'h1111 || rd2[i] !== 32'd0) begin
            errors++; $display("FAIL reset_rd[%0d]: got %h %h expected 00001111 00000000", i, rd1[i], rd2[i]);
         end
      end
      rst = 1'b0;
      idle_inputs();
      tick();
   endtask

   task automatic test_single();
      a_valid[0] = 1'b1; a_ws[0] = 5'd5; a_wd[0] = 32'hDEADBEEF;
      @(negedge clk);
      checks++;
      if (a_ready[0] !== 1'b1 || b_ready[0] !== 1'b0) begin
         errors++; $display("FAIL single_ready: got a=%b b=%b expected 1 0", a_ready[0], b_ready[0]);
      end
      tick();
      a_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (rf_we[0] !== 1'b1 || rf_ws[0] !== 5'd5 || rf_wd[0] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL single_write: got we=%b ws=%0d wd=%h expected 1 5 deadbeef", rf_we[0], rf_ws[0], rf_wd[0]);
      end
      tick();
      @(negedge clk);
      checks++;
      if (rf_we[0] !== 1'b0 || rf_ws[0] !== 5'd5 || rf_wd[0] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL single_idle: got we=%b ws=%0d wd=%h expected 0 5 deadbeef", rf_we[0], rf_ws[0], rf_wd[0]);
      end
      tick();
   endtask

   task automatic test_rr_tie();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         a_valid[0] = (c < 4); a_ws[0] = 5'd3; a_wd[0] = 32'h11;
         b_valid[0] = (c < 4); b_ws[0] = 5'd4; b_wd[0] = 32'h22;
         @(negedge clk);
         if (c < 4) begin
            checks++;
            if (a_ready[0] !== 1'((c % 2) == 0) || b_ready[0] !== 1'((c % 2) == 1)) begin
               errors++; $display("FAIL rr_grant c%0d: got a=%b b=%b expected a=%b", c, a_ready[0], b_ready[0], (c % 2) == 0);
            end
         end
         if (c >= 1) begin
            checks++;
            if (rf_we[0] !== 1'b1 || rf_ws[0] !== ((c % 2) == 1 ? 5'd3 : 5'd4)) begin
               errors++; $display("FAIL rr_ws c%0d: got we=%b ws=%0d expected 1 %0d", c, rf_we[0], rf_ws[0], (c % 2) == 1 ? 3 : 4);
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_fixed_prio();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         a_valid[1] = (c < 3); a_ws[1] = 5'd1; a_wd[1] = 32'hA1;
         b_valid[1] = (c < 4); b_ws[1] = 5'd2; b_wd[1] = 32'hB2;
         @(negedge clk);
         if (c < 4) begin
            checks++;
            if (a_ready[1] !== 1'(c < 3) || b_ready[1] !== 1'(c == 3)) begin
               errors++; $display("FAIL fixed_grant c%0d: got a=%b b=%b expected b only in c3", c, a_ready[1], b_ready[1]);
            end
         end else begin
            checks++;
            if (rf_we[1] !== 1'b1 || rf_ws[1] !== 5'd2 || rf_wd[1] !== 32'hB2) begin
               errors++; $display("FAIL fixed_bwrite: got we=%b ws=%0d wd=%h expected 1 2 b2", rf_we[1], rf_ws[1], rf_wd[1]);
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_x0_discard();
      b_valid[0] = 1'b1; b_ws[0] = 5'd0; b_wd[0] = 32'hFFFFFFFF;
      @(negedge clk);
      checks++;
      if (b_ready[0] !== 1'b1) begin
         errors++; $display("FAIL x0_ready: got %b expected 1", b_ready[0]);
      end
      tick();
      a_valid[0] = 1'b1; a_ws[0] = 5'd9;  a_wd[0] = 32'h99;
      b_valid[0] = 1'b1; b_ws[0] = 5'd10; b_wd[0] = 32'hAA;
      @(negedge clk);
      checks++;
      if (rf_we[0] !== 1'b0) begin
         errors++; $display("FAIL x0_we: got %b expected 0", rf_we[0]);
      end
      checks++;
      if (a_ready[0] !== 1'b1 || b_ready[0] !== 1'b0) begin
         errors++; $display("FAIL x0_tie: got a=%b b=%b expected 1 0", a_ready[0], b_ready[0]);
      end
      tick();
      a_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (rf_we[0] !== 1'b1 || rf_ws[0] !== 5'd9 || rf_wd[0] !== 32'h99 || b_ready[0] !== 1'b1) begin
         errors++; $display("FAIL x0_after: got we=%b ws=%0d wd=%h bready=%b expected 1 9 99 1", rf_we[0], rf_ws[0], rf_wd[0], b_ready[0]);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (rf_we[0] !== 1'b1 || rf_ws[0] !== 5'd10 || rf_wd[0] !== 32'hAA) begin
         errors++; $display("FAIL x0_bwrite: got we=%b ws=%0d wd=%h expected 1 10 aa", rf_we[0], rf_ws[0], rf_wd[0]);
      end
      tick();
   endtask

   task automatic test_bypass();
      a_valid[0] = 1'b1; a_ws[0] = 5'd7; a_wd[0] = 32'h1234;
      tick();
      a_valid[0] = 1'b0;
      rs1 = 5'd7; rs2 = 5'd8; rf_rd1 = 32'hAAAA; rf_rd2 = 32'hBBBB;
      @(negedge clk);
      checks++;
      if (rd1[0] !== 32'h1234 || rd2[0] !== 32'hBBBB) begin
         errors++; $display("FAIL bypass_hit: got %h %h expected 00001234 0000bbbb", rd1[0], rd2[0]);
      end
      rs1 = 5'd0; rs2 = 5'd7;
      #1;
      checks++;
      if (rd1[0] !== 32'd0 || rd2[0] !== 32'h1234) begin
         errors++; $display("FAIL bypass_x0: got %h %h expected 00000000 00001234", rd1[0], rd2[0]);
      end
      tick();
      rs1 = 5'd7;
      @(negedge clk);
      checks++;
      if (rd1[0] !== 32'hAAAA) begin
         errors++; $display("FAIL bypass_stale: got %h expected 0000aaaa", rd1[0]);
      end
      tick();
   endtask

   task automatic test_same_reg();
      do_reset();
      a_valid[0] = 1'b1; a_ws[0] = 5'd6; a_wd[0] = 32'hA;
      b_valid[0] = 1'b1; b_ws[0] = 5'd6; b_wd[0] = 32'hB;
      @(negedge clk);
      checks++;
      if (a_ready[0] !== 1'b1 || b_ready[0] !== 1'b0) begin
         errors++; $display("FAIL same_first: got a=%b b=%b expected 1 0", a_ready[0], b_ready[0]);
      end
      tick();
      a_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (b_ready[0] !== 1'b1 || rf_ws[0] !== 5'd6 || rf_wd[0] !== 32'hA) begin
         errors++; $display("FAIL same_second: got bready=%b ws=%0d wd=%h expected 1 6 a", b_ready[0], rf_ws[0], rf_wd[0]);
      end
      tick();
      b_valid[0] = 1'b0;
      rs1 = 5'd6; rf_rd1 = 32'hA;
      @(negedge clk);
      checks++;
      if (rf_we[0] !== 1'b1 || rf_wd[0] !== 32'hB || rd1[0] !== 32'hB) begin
         errors++; $display("FAIL same_last: got we=%b wd=%h rd1=%h expected 1 b b", rf_we[0], rf_wd[0], rd1[0]);
      end
      tick();
      rf_rd1 = 32'hB;
      @(negedge clk);
      checks++;
      if (rf_we[0] !== 1'b0 || rd1[0] !== 32'hB) begin
         errors++; $display("FAIL same_final: got we=%b rd1=%h expected 0 b", rf_we[0], rd1[0]);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      a_valid[0] = 1'b1; a_ws[0] = 5'd12; a_wd[0] = 32'h55;
      @(negedge clk);
      checks++;
      if (a_ready[0] !== 1'b1) begin
         errors++; $display("FAIL midrst_xfer: got %b expected 1", a_ready[0]);
      end
      tick();
      rst = 1'b1;
      a_ws[0] = 5'd13; a_wd[0] = 32'h66;
      b_valid[0] = 1'b1; b_ws[0] = 5'd14; b_wd[0] = 32'h77;
      rs1 = 5'd12; rf_rd1 = 32'h0;
      @(negedge clk);
      checks++;
      if (a_ready[0] !== 1'b0 || b_ready[0] !== 1'b0 || rf_we[0] !== 1'b1 || rd1[0] !== 32'h55) begin
         errors++; $display("FAIL midrst_n1: got a=%b b=%b we=%b rd1=%h expected 0 0 1 55", a_ready[0], b_ready[0], rf_we[0], rd1[0]);
      end
      tick();
      @(negedge clk);
      checks++;
      if (a_ready[0] !== 1'b0 || b_ready[0] !== 1'b0 || rf_we[0] !== 1'b0 || rd1[0] !== 32'h0) begin
         errors++; $display("FAIL midrst_n2: got a=%b b=%b we=%b rd1=%h expected 0 0 0 0", a_ready[0], b_ready[0], rf_we[0], rd1[0]);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (a_ready[0] !== 1'b1 || b_ready[0] !== 1'b0 || rf_we[0] !== 1'b0) begin
         errors++; $display("FAIL midrst_release: got a=%b b=%b we=%b expected 1 0 0", a_ready[0], b_ready[0], rf_we[0]);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (rf_we[0] !== 1'b1 || rf_ws[0] !== 5'd13 || rf_wd[0] !== 32'h66) begin
         errors++; $display("FAIL midrst_write: got we=%b ws=%0d wd=%h expected 1 13 66", rf_we[0], rf_ws[0], rf_wd[0]);
      end
      tick();
   endtask

   task automatic test_random();
      bit          pend [2][2];
      logic [4:0]  pws  [2][2];
      logic [31:0] pwd  [2][2];
      bit          ga [2];
      bit          gb [2];
      do_reset();
      for (int i = 0; i < 2; i++) for (int s = 0; s < 2; s++) pend[i][s] = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         rst = ($urandom_range(0, 49) == 0);
         for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 2; s++) begin
               if (!pend[i][s] && $urandom_range(0, 2) != 0) begin
                  pend[i][s] = 1'b1;
                  pws[i][s]  = 5'($urandom_range(0, 7));
                  pwd[i][s]  = $urandom;
               end
            end
            a_valid[i] = pend[i][0]; a_ws[i] = pws[i][0]; a_wd[i] = pwd[i][0];
            b_valid[i] = pend[i][1]; b_ws[i] = pws[i][1]; b_wd[i] = pwd[i][1];
         end
         rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
         rf_rd1 = $urandom; rf_rd2 = $urandom;
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            arb(rst, pend[i][0], pend[i][1], i, m_last[i], ga[i], gb[i]);
            checks++;
            if (a_ready[i] !== ga[i] || b_ready[i] !== gb[i]) begin
               errors++; $display("FAIL rand_ready[%0d] cyc%0d: got a=%b b=%b expected a=%b b=%b", i, cyc, a_ready[i], b_ready[i], ga[i], gb[i]);
            end
            checks++;
            if (rf_we[i] !== m_we[i] || (m_known[i] && (rf_ws[i] !== m_ws[i] || rf_wd[i] !== m_wd[i]))) begin
               errors++; $display("FAIL rand_port[%0d] cyc%0d: got we=%b ws=%0d wd=%h expected we=%b ws=%0d wd=%h", i, cyc, rf_we[i], rf_ws[i], rf_wd[i], m_we[i], m_ws[i], m_wd[i]);
            end
            checks++;
            if (rd1[i] !== exp_rd(i, rs1, rf_rd1) || rd2[i] !== exp_rd(i, rs2, rf_rd2)) begin
               errors++; $display("FAIL rand_rd[%0d] cyc%0d: got %h %h expected %h %h", i, cyc, rd1[i], rd2[i], exp_rd(i, rs1, rf_rd1), exp_rd(i, rs2, rf_rd2));
            end
         end
         tick();
         for (int i = 0; i < 2; i++) begin
            if (rst) begin
               m_last[i] = 1; m_we[i] = 1'b0; m_ws[i] = 5'd0; m_wd[i] = 32'd0; m_known[i] = 1'b1;
            end else if (ga[i] || gb[i]) begin
               int s;
               s = ga[i] ? 0 : 1;
               m_last[i] = s;
               pend[i][s] = 1'b0;
               if (pws[i][s] != 5'd0) begin
                  m_we[i] = 1'b1; m_ws[i] = pws[i][s]; m_wd[i] = pwd[i][s]; m_known[i] = 1'b1;
               end else begin
                  m_we[i] = 1'b0; m_known[i] = 1'b0;
               end
            end else begin
               m_we[i] = 1'b0;
            end
         end
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      rs1 = 5'd0; rs2 = 5'd0; rf_rd1 = 32'd0; rf_rd2 = 32'd0;
      test_reset();
      test_single();
      test_rr_tie();
      test_fixed_prio();
      test_x0_discard();
      test_bypass();
      test_same_reg();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have one parameter: FIXED_PRIO, default 0, 0 = round-robin between sources, 1 = source A always wins.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- a_valid  in  1  source A (ALU writeback) write request.
- a_ws  in  5  source A destination register.
- a_wd  in  32  source A write data.
- a_ready  out  1  source A request accepted this cycle.
- b_valid  in  1  source B (load writeback) write request.
- b_ws  in  5  source B destination register.
- b_wd  in  32  source B write data.
- b_ready  out  1  source B request accepted this cycle.
- rf_we  out  1  register-file write enable, registered.
- rf_ws  out  5  register-file write select, registered.
- rf_wd  out  32  register-file write data, registered.
- rs1, rs2  in  5 each  read selects (also driven to the register file).
- rf_rd1, rf_rd2  in  32 each  raw register-file read data.
- rd1, rd2  out  32 each  bypassed read data.

Function
REQ-004 A transfer SHALL occur on source X in a cycle iff x_valid && x_ready; the source holds valid, ws and wd stable until the transfer.
REQ-005 a_ready and b_ready SHALL be combinational, never high together, and low whenever rst is high.
REQ-006 When exactly one source is valid, that source SHALL get ready = 1 in the same cycle.
REQ-007 When both sources are valid and FIXED_PRIO = 0, the winner SHALL be the source not granted most recently (last_grant register).
- The loser SHALL win in the next cycle if it is still valid.
- Maximum wait is therefore 1 cycle.
REQ-008 When both sources are valid and FIXED_PRIO = 1, A SHALL always win; B SHALL wait until a_valid = 0.
REQ-009 last_grant SHALL update on every transfer, including transfers discarded under REQ-011.
REQ-010 Latency SHALL be 1 cycle.
- A transfer in cycle N drives rf_we = 1, rf_ws = ws and rf_wd = wd in cycle N+1.
- The register file commits the write at the end of cycle N+1.
REQ-011 A transfer with ws = 0 SHALL be accepted (ready = 1) but SHALL leave rf_we = 0 in cycle N+1.
REQ-012 In any cycle with no transfer, the following cycle SHALL have rf_we = 0; rf_ws and rf_wd SHALL hold their previous values.
REQ-013 rdK (K = 1, 2) SHALL equal rf_wd when rf_we = 1, rf_ws = rsK and rsK != 0; otherwise rdK SHALL equal rf_rdK.
REQ-014 rdK SHALL be 32'b0 whenever rsK = 0, regardless of rf_rdK.
REQ-015 Both sources targeting the same register SHALL be serialized in grant order; the register file SHALL end holding the later-granted data.
REQ-016 The block SHALL contain exactly two state elements: the output stage (rf_we, rf_ws, rf_wd) and last_grant. There is no request buffering; a lost request is the source's responsibility.

Reset
REQ-017 While rst = 1 at a posedge, the block SHALL set rf_we = 0, rf_ws = 0, rf_wd = 0 and last_grant = B, so A wins the first tie.
REQ-018 While rst is high, no transfer SHALL occur; a request pending when rst is asserted mid-operation SHALL be dropped, and its registered write SHALL be cleared at that edge.
REQ-019 rd1 and rd2 SHALL remain purely combinational under REQ-013 and REQ-014 during reset; with rf_we = 0 they pass rf_rd1 and rf_rd2.

Verification
REQ-020 Single source: a_valid = 1, a_ws = 5, a_wd = 0xDEADBEEF in cycle 0 -> a_ready = 1 in cycle 0; cycle 1 shows rf_we = 1, rf_ws = 5, rf_wd = 0xDEADBEEF; cycle 2 shows rf_we = 0.
REQ-021 Round-robin tie after reset, with A (ws = 3, wd = 0x11) and B (ws = 4, wd = 0x22) held valid -> grants in order A, B, A, B; rf_ws sequence from cycle 1 is 3, 4, 3, 4.
REQ-022 FIXED_PRIO = 1, both valid for 3 cycles then A drops -> B is granted only in cycle 3.
REQ-023 x0 discard: b_valid = 1, b_ws = 0, b_wd = 0xFFFFFFFF -> b_ready = 1; next cycle rf_we = 0; a following A/B tie grants A.
REQ-024 Bypass: with rf_we = 1, rf_ws = 7, rf_wd = 0x1234, rs1 = 7, rs2 = 8, rf_rd1 = 0xAAAA, rf_rd2 = 0xBBBB -> rd1 = 0x1234, rd2 = 0xBBBB; with rs1 = 0 -> rd1 = 0.
REQ-025 Reset mid-operation: A transfers in cycle N and rst = 1 in cycle N+1 -> rf_we = 0 from cycle N+2, both readies low while rst = 1, and the first tie after release grants A.
